aurora_tx_gearbox: RTL and testbench
====================================

# aurora_tx_gearbox

Per-lane 66-to-64 TX gearbox directly downstream of `aurora_top`. It consumes the 66-bit encoded blocks on `encoded_data` (all `MAX_LINKS` lanes in lockstep) and repacks them into a continuous 64-bit-per-cycle stream for the transceiver PCS. One shared 33-state sequence counter throttles the upstream encoder, which stalls one cycle in 33, and the counter value is exported for GTs that use an external sequence input.

## Interface
- No module parameters. All widths come from `aurora_pkg`.
- `clk`  in  1  single clock, used for all logic.
- `rst`  in  1  synchronous reset, active-high.
- `encoded_valid`  in  1  `encoded_data` holds a new block on every lane.
- `encoded_data`  in  `[MAX_LINKS-1:0][ENCODED_DATA_SIZE-1:0]`  66-bit blocks:
  - `[1:0]` is the sync header, transmitted first.
  - `[65:2]` is the payload.
- `encoded_ready`  out  1  gearbox accepts a block this cycle.
- `tx_data`  out  `[MAX_LINKS-1:0][GB_DATA_SIZE-1:0]`  64-bit words; bit 0 is transmitted first.
- `tx_valid`  out  1  `tx_data` is valid this cycle.
- `tx_seq`  out  6  sequence value 0..32 belonging to the current `tx_data`.
- `underflow`  out  1  sticky flag: a block was missing while `encoded_ready` was high.

## Operation
- Per lane: a 130-bit residue buffer and a fill count. The fill count is shared by all lanes because they run in lockstep.
- Counter `seq` runs 0..32 and wraps to 0.
- `encoded_ready = !rst && (seq != 32)`. This is combinational from registered `seq`.
- Accept cycle (seq = k, k < 32):
  - Residue before the cycle is 2k bits; the block is appended above it.
  - Low 64 bits go to `tx_data`; residue after the cycle is 2(k+1) bits.
  - `seq` increments.
- seq = 31 leaves 64 residue bits. seq = 32 accepts nothing, outputs those 64 bits, and leaves residue 0.
- Missing block (ready high, `encoded_valid` low): behaviour depends on the Configuration macro. `underflow` is set in both cases.
- `underflow` is cleared only by `rst`.
- `encoded_valid` while `encoded_ready` is low is ignored. Upstream must hold the block; this matches `aurora_top` stalling one cycle.

## Timing
- All outputs are registered except `encoded_ready`.
- Latency: a block accepted in cycle t contributes its first bits to `tx_data` in cycle t+1.
- Reset values:
  - `tx_data` = 0, `tx_valid` = 0, `tx_seq` = 0, `underflow` = 0.
  - `encoded_ready` = 0 while `rst` is high.
  - Internal `seq` = 0, residue = 0.
- First cycle after `rst` deasserts: `encoded_ready` = 1 and `seq` = 0.
- `tx_seq` lags internal `seq` by one cycle, aligned with `tx_data`.
- Steady state: the output pattern repeats every 33 cycles, with `encoded_ready` low for 1 of them.
- Reset mid-frame: residue is discarded with no partial word flushed. Next cycle `tx_valid` = 0 and `seq` = 0.
- Reset has priority over accept and underflow in the same cycle.

## Configuration
- `AURORA_GEARBOX_IDLE_FILL_EN` defined:
  - A missing block is replaced by `IDLE_BLOCK` on every lane.
  - `seq` advances normally and `tx_valid` stays 1, so the line rate is preserved.
- Macro undefined:
  - A missing block freezes `seq` and the residue.
  - `tx_valid` = 0 in the following cycle; `tx_data` keeps its previous value.

## Structure
- `aurora_pkg` additions:
  - `GB_DATA_SIZE = 64`
  - `GB_SEQ_MAX = 32`
  - `IDLE_BLOCK`: bits `[1:0]` = `2'b10`, bits `[9:2]` = `8'h78`, all other bits 0.
  - Typedef `gb_word_t`.
- Existing package constants reused: `MAX_LINKS`, `ENCODED_DATA_SIZE`.
- Sub-module `aurora_tx_gearbox_lane`: holds the per-lane residue buffer, driven by shared `seq` and accept/idle strobes. The top instantiates `MAX_LINKS` of them and owns the counter and `underflow`.

## Test plan
- Reset 2 cycles, then `encoded_valid` = 1 continuously, blocks = counter pattern:
  - `encoded_ready` is low only in the 33rd cycle after reset and every 33 cycles after that.
  - `tx_seq` steps 0..32 and wraps.
- Block0 = `66'h2_0000_0000_0000_0001`, block1 = all-zero payload with header `2'b01`:
  - `tx_data` word0 = `64'h0000_0000_0000_0001`.
  - word1 `[1:0]` = `2'b10` (block0 bits `[65:64]`) and word1 `[3:2]` = `2'b01`.
- With `AURORA_GEARBOX_IDLE_FILL_EN`, drop `encoded_valid` at seq 5:
  - The `IDLE_BLOCK` bits appear at the next word offset 10.
  - `tx_valid` stays 1 and `underflow` = 1 until `rst`.
- Without the macro, same stimulus:
  - One cycle `tx_valid` = 0 and `tx_seq` repeats.
  - Reassembled bit stream is identical to the no-gap case.
- Assert `rst` at seq 17:
  - Next cycle `tx_valid` = 0 and `encoded_ready` = 0.
  - After release, word0 equals the first new block's `[63:0]`; no stale residue.
- `MAX_LINKS` lanes fed distinct patterns (lane i payload = i):
  - Each lane's reassembled output stream matches its own input blocks, bit-exact over 66 cycles.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared Aurora constants and types, including the 66-to-64 TX gearbox additions.
package aurora_pkg;

    localparam int unsigned MAX_LINKS         = 4;
    localparam int unsigned ENCODED_DATA_SIZE = 66;

    localparam int unsigned GB_DATA_SIZE    = 64;
    localparam int unsigned GB_SEQ_MAX      = 32;
    localparam int unsigned GB_SEQ_W        = 6;
    localparam int unsigned GB_RESIDUE_SIZE = 130;

    typedef logic [GB_DATA_SIZE-1:0]      gb_word_t;
    typedef logic [ENCODED_DATA_SIZE-1:0] encoded_block_t;
    typedef logic [GB_SEQ_W-1:0]          gb_seq_t;

    localparam gb_seq_t GB_SEQ_LAST = gb_seq_t'(GB_SEQ_MAX);

    // Sync header 2'b10 (control) with block type 8'h78, remaining bits zero.
    localparam encoded_block_t IDLE_BLOCK = {56'h0, 8'h78, 2'b10};

endpackage

// File: rtl/aurora_tx_gearbox_lane.sv
// One lane of the 66-to-64 TX gearbox: residue buffer plus registered output word.
// Fill level is 2*seq bits and is owned by the parent.
module aurora_tx_gearbox_lane
    import aurora_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  gb_seq_t        seq,
    input  logic           load,
    input  logic           flush,
    input  encoded_block_t block,
    output gb_word_t       tx_data
);

    logic [GB_RESIDUE_SIZE-1:0] residue_q, residue_d, merged;
    gb_word_t                   data_q, data_d;

    always_comb begin
        merged    = residue_q | (GB_RESIDUE_SIZE'(block) << {seq, 1'b0});
        residue_d = residue_q;
        data_d    = data_q;
        if (load) begin
            data_d    = merged[GB_DATA_SIZE-1:0];
            residue_d = merged >> GB_DATA_SIZE;
        end else if (flush) begin
            // seq 32: residue holds exactly one word
            data_d    = residue_q[GB_DATA_SIZE-1:0];
            residue_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            residue_q <= '0;
            data_q    <= '0;
        end else begin
            residue_q <= residue_d;
            data_q    <= data_d;
        end
    end

    assign tx_data = data_q;

endmodule

// File: rtl/aurora_tx_gearbox.sv
// 66-to-64 TX gearbox for all lanes in lockstep with a shared 33-state sequence counter.
// Optional AURORA_GEARBOX_IDLE_FILL_EN replaces missing blocks with IDLE_BLOCK.
module aurora_tx_gearbox
    import aurora_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             encoded_valid,
    input  logic [MAX_LINKS-1:0][ENCODED_DATA_SIZE-1:0]      encoded_data,
    output logic                                             encoded_ready,
    output logic [MAX_LINKS-1:0][GB_DATA_SIZE-1:0]           tx_data,
    output logic                                             tx_valid,
    output logic [5:0]                                       tx_seq,
    output logic                                             underflow
);

    gb_seq_t seq_q, seq_d;
    gb_seq_t tx_seq_q, tx_seq_d;
    logic    tx_valid_q, tx_valid_d;
    logic    underflow_q, underflow_d;
    logic    load, flush, missing;

    assign encoded_ready = !rst && (seq_q != GB_SEQ_LAST);
    assign flush         = !rst && (seq_q == GB_SEQ_LAST);
    assign missing       = encoded_ready && !encoded_valid;

`ifdef AURORA_GEARBOX_IDLE_FILL_EN
    assign load = encoded_ready;
`else
    assign load = encoded_ready && encoded_valid;
`endif

    always_comb begin
        seq_d       = seq_q;
        tx_seq_d    = tx_seq_q;
        tx_valid_d  = 1'b0;
        underflow_d = underflow_q | missing;
        if (load || flush) begin
            seq_d      = (seq_q == GB_SEQ_LAST) ? '0 : seq_q + gb_seq_t'(1);
            tx_seq_d   = seq_q;
            tx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q       <= '0;
            tx_seq_q    <= '0;
            tx_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            tx_seq_q    <= tx_seq_d;
            tx_valid_q  <= tx_valid_d;
            underflow_q <= underflow_d;
        end
    end

    for (genvar i = 0; i < MAX_LINKS; i++) begin : g_lane
        encoded_block_t lane_block;
`ifdef AURORA_GEARBOX_IDLE_FILL_EN
        assign lane_block = encoded_valid ? encoded_data[i] : IDLE_BLOCK;
`else
        assign lane_block = encoded_data[i];
`endif
        aurora_tx_gearbox_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .seq     (seq_q),
            .load    (load),
            .flush   (flush),
            .block   (lane_block),
            .tx_data (tx_data[i])
        );
    end

    assign tx_valid  = tx_valid_q;
    assign tx_seq    = tx_seq_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_aurora_tx_gearbox.sv
// Self-checking bench for aurora_tx_gearbox: a bit-serial queue reference model fed by
// directed and randomized steps; honours AURORA_GEARBOX_IDLE_FILL_EN.
module tb_aurora_tx_gearbox;
    import aurora_pkg::*;

    localparam int unsigned DW = MAX_LINKS * GB_DATA_SIZE;
    localparam int unsigned BW = MAX_LINKS * ENCODED_DATA_SIZE;

    logic                                        clk = 1'b0;
    logic                                        rst;
    logic                                        encoded_valid;
    logic [MAX_LINKS-1:0][ENCODED_DATA_SIZE-1:0] encoded_data;
    logic                                        encoded_ready;
    logic [MAX_LINKS-1:0][GB_DATA_SIZE-1:0]      tx_data;
    logic                                        tx_valid;
    logic [5:0]                                  tx_seq;
    logic                                        underflow;

    aurora_tx_gearbox dut (
        .clk           (clk),
        .rst           (rst),
        .encoded_valid (encoded_valid),
        .encoded_data  (encoded_data),
        .encoded_ready (encoded_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_seq        (tx_seq),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transmit-order bit stream: each entry is one bit time, one bit per lane.
    logic [MAX_LINKS-1:0] bq[$];
    logic [DW-1:0]        exp_data;
    logic                 exp_valid;
    logic [5:0]           exp_seq;
    logic                 exp_uf;
    int                   word_cnt;
    int                   accepted;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
        n_tests++;
        assert (obs === req)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic push_block(input logic [BW-1:0] d);
        logic [MAX_LINKS-1:0] e;
        for (int b = 0; b < int'(ENCODED_DATA_SIZE); b++) begin
            for (int l = 0; l < int'(MAX_LINKS); l++) e[l] = d[l*ENCODED_DATA_SIZE + b];
            bq.push_back(e);
        end
    endtask

    // Called #1 after a rising edge: drive, check ready, model, advance, check outputs.
    task automatic cycle(input logic r, input logic v, input logic [BW-1:0] d);
        logic                 exp_ready;
        logic                 produce;
        logic [MAX_LINKS-1:0] e;
        logic [BW-1:0]        idle_all;
        rst           = r;
        encoded_valid = v;
        encoded_data  = d;
        #1;
        exp_ready = !r && (bq.size() != 64);
        check("encoded_ready", DW'(encoded_ready), DW'(exp_ready));
        produce = 1'b0;
        if (r) begin
            bq.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_seq   = '0;
            exp_uf    = 1'b0;
            word_cnt  = 0;
            accepted  = 0;
        end else begin
            if (exp_ready) begin
                if (v) begin
                    push_block(d);
                    produce = 1'b1;
                    accepted++;
                end else begin
                    exp_uf = 1'b1;
`ifdef AURORA_GEARBOX_IDLE_FILL_EN
                    for (int l = 0; l < int'(MAX_LINKS); l++)
                        idle_all[l*ENCODED_DATA_SIZE +: ENCODED_DATA_SIZE] = IDLE_BLOCK;
                    push_block(idle_all);
                    produce = 1'b1;
`endif
                end
            end else begin
                produce = 1'b1;
            end
            if (produce) begin
                for (int b = 0; b < int'(GB_DATA_SIZE); b++) begin
                    e = bq.pop_front();
                    for (int l = 0; l < int'(MAX_LINKS); l++) exp_data[l*GB_DATA_SIZE + b] = e[l];
                end
                exp_seq  = 6'(word_cnt);
                word_cnt = (word_cnt == 32) ? 0 : word_cnt + 1;
            end
            exp_valid = produce;
        end
        @(posedge clk);
        #1;
        check("tx_data", DW'(tx_data), exp_data);
        check("tx_valid", DW'(tx_valid), DW'(exp_valid));
        check("tx_seq", DW'(tx_seq), DW'(exp_seq));
        check("underflow", DW'(underflow), DW'(exp_uf));
    endtask

    function automatic logic [BW-1:0] rand_blocks();
        logic [BW-1:0] d;
        for (int i = 0; i < int'(BW); i += 32) d[i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [BW-1:0] same_block(input logic [65:0] blk);
        logic [BW-1:0] d;
        for (int l = 0; l < int'(MAX_LINKS); l++) d[l*ENCODED_DATA_SIZE +: ENCODED_DATA_SIZE] = blk;
        return d;
    endfunction

    function automatic logic [BW-1:0] lane_pattern();
        logic [BW-1:0] d;
        for (int l = 0; l < int'(MAX_LINKS); l++)
            d[l*ENCODED_DATA_SIZE +: ENCODED_DATA_SIZE] = {64'(l), 2'b01};
        return d;
    endfunction

    initial begin
        logic [BW-1:0] d;
        logic [65:0]   blk;
        rst           = 1'b1;
        encoded_valid = 1'b0;
        encoded_data  = '0;
        #1;

        // Reset, then continuous random blocks across more than two frames.
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1, rand_blocks());

        // Directed first two blocks.
        cycle(1'b1, 1'b0, '0);
        blk = 66'h2_0000_0000_0000_0001;
        cycle(1'b0, 1'b1, same_block(blk));
        check("word0_direct", DW'(tx_data[0]), DW'(64'h1));
        blk = 66'h1;
        cycle(1'b0, 1'b1, same_block(blk));
        check("word1_low_bits", DW'(tx_data[0][3:0]), DW'(4'b0110));

        // Missing block at seq 5.
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, rand_blocks());
        cycle(1'b0, 1'b0, rand_blocks());
`ifdef AURORA_GEARBOX_IDLE_FILL_EN
        check("idle_at_offset10", DW'(tx_data[1][19:10]), DW'({8'h78, 2'b10}));
        check("idle_valid", DW'(tx_valid), DW'(1'b1));
`else
        check("stall_valid_low", DW'(tx_valid), DW'(1'b0));
        check("stall_seq_repeat", DW'(tx_seq), DW'(6'd4));
`endif
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, rand_blocks());
        check("underflow_sticky", DW'(underflow), DW'(1'b1));

        // Random gaps.
        for (int i = 0; i < 80; i++) cycle(1'b0, ($urandom_range(0, 7) != 0), rand_blocks());

        // Reset mid-frame at seq 17.
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, rand_blocks());
        cycle(1'b1, 1'b1, rand_blocks());
        check("midreset_ready", DW'(encoded_ready), DW'(1'b0));
        d = rand_blocks();
        cycle(1'b0, 1'b1, d);
        check("post_reset_word0", DW'(tx_data[0]), DW'(d[63:0]));

        // Distinct per-lane patterns over two full frames.
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 66; i++) cycle(1'b0, 1'b1, lane_pattern());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
